ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu_if.sv | 24 ++
 rtl/ifu.sv | 123 ++++++++++++
 tb/tb_ifu.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ifu_if.sv
// Fetch-unit bus: control-unit PC select, instruction memory, A bus and branch trace port.
interface ifu_if;
  logic [1:0]  ps_in;
  logic        il_in;
  logic [15:0] imem_data_in;
  logic [15:0] a_in;
  logic [15:0] pc_out;
  logic [15:0] ins_out;
  logic [31:0] icount_out;
  logic        trace_rd_in;
  logic        trace_valid_out;
  logic [15:0] trace_data_out;
  logic        trace_ovf_out;

  modport master (
    output ps_in, il_in, imem_data_in, a_in, trace_rd_in,
    input  pc_out, ins_out, icount_out, trace_valid_out, trace_data_out, trace_ovf_out
  );

  modport slave (
    input  ps_in, il_in, imem_data_in, a_in, trace_rd_in,
    output pc_out, ins_out, icount_out, trace_valid_out, trace_data_out, trace_ovf_out
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: PC sequencing, instruction register, fetch counter.
// Optional 4-deep branch-source trace FIFO built when IFU_TRACE_EN is defined.
module ifu #(
  parameter logic [15:0] PC_RST = 16'h0000
) (
  input  logic clk,
  input  logic rst_n,
  ifu_if.slave bus
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned OFF_W  = 6;

  logic [DATA_W-1:0] pc_q, pc_nxt;
  logic [DATA_W-1:0] ins_q;
  logic [CNT_W-1:0]  icnt_q;
  logic [OFF_W-1:0]  br_off;
  logic [DATA_W-1:0] br_off_sx;

  // Branch offset comes from the instruction held before any load this cycle
  assign br_off    = {ins_q[8:6], ins_q[2:0]};
  assign br_off_sx = {{(DATA_W-OFF_W){br_off[OFF_W-1]}}, br_off};

  always_comb begin
    pc_nxt = pc_q;
    unique case (bus.ps_in)
      2'b01:   pc_nxt = pc_q + DATA_W'(1);
      2'b10:   pc_nxt = pc_q + br_off_sx;
      2'b11:   pc_nxt = bus.a_in;
      default: pc_nxt = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= PC_RST;
      ins_q  <= '0;
      icnt_q <= '0;
    end else begin
      pc_q <= pc_nxt;
      if (bus.il_in) begin
        ins_q <= bus.imem_data_in;
        if (icnt_q != '1) icnt_q <= icnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc_out     = pc_q;
  assign bus.ins_out    = ins_q;
  assign bus.icount_out = icnt_q;

`ifdef IFU_TRACE_EN
  localparam int unsigned TRACE_DEPTH = 4;
  localparam int unsigned TCNT_W      = 3;
  localparam int unsigned TIDX_W      = 2;

  // Shift queue: entry 0 is oldest, slots at or above the count are kept zero
  logic [DATA_W-1:0] tq_q   [TRACE_DEPTH];
  logic [DATA_W-1:0] tq_nxt [TRACE_DEPTH];
  logic [TCNT_W-1:0] tcnt_q, tcnt_nxt;
  logic [TIDX_W-1:0] widx;
  logic              ovf_q, ovf_nxt;
  logic              tvalid_q;
  logic              push, pop, full;

  always_comb begin
    tq_nxt   = tq_q;
    tcnt_nxt = tcnt_q;
    ovf_nxt  = ovf_q;
    widx     = '0;
    push     = bus.ps_in[1];
    pop      = bus.trace_rd_in && (tcnt_q != '0);
    full     = (tcnt_q == TCNT_W'(TRACE_DEPTH));

    if (pop || (push && full)) begin
      tq_nxt[0] = tq_q[1];
      tq_nxt[1] = tq_q[2];
      tq_nxt[2] = tq_q[3];
      tq_nxt[3] = '0;
    end

    if (push) begin
      if (pop) begin
        widx = TIDX_W'(tcnt_q - TCNT_W'(1));
      end else if (full) begin
        widx    = TIDX_W'(TRACE_DEPTH - 1);
        ovf_nxt = 1'b1;
      end else begin
        widx     = TIDX_W'(tcnt_q);
        tcnt_nxt = tcnt_q + TCNT_W'(1);
      end
      tq_nxt[widx] = pc_q;
    end else if (pop) begin
      tcnt_nxt = tcnt_q - TCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tq_q     <= '{default: '0};
      tcnt_q   <= '0;
      ovf_q    <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      tq_q     <= tq_nxt;
      tcnt_q   <= tcnt_nxt;
      ovf_q    <= ovf_nxt;
      tvalid_q <= (tcnt_nxt != '0);
    end
  end

  assign bus.trace_valid_out = tvalid_q;
  assign bus.trace_data_out  = tq_q[0];
  assign bus.trace_ovf_out   = ovf_q;
`else
  logic unused_trace_rd;
  assign unused_trace_rd     = bus.trace_rd_in;
  assign bus.trace_valid_out = 1'b0;
  assign bus.trace_data_out  = '0;
  assign bus.trace_ovf_out   = 1'b0;
`endif

endmodule

// File: tb/tb_ifu.sv
// Randomized self-checking bench for ifu against a queue/arithmetic reference model.
module tb_ifu;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  ifu_if bus();

  ifu #(.PC_RST(16'h0010)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] m_ins;
  logic [31:0] m_icnt;
  logic        m_ovf;
  logic [15:0] m_tq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = 16'h0010;
    m_ins  = 16'h0000;
    m_icnt = 32'd0;
    m_ovf  = 1'b0;
    m_tq   = {};
  endtask

  task automatic model_clock(input logic [1:0] ps, input logic il, input logic [15:0] imem,
                             input logic [15:0] a, input logic rd);
    logic [15:0] old_pc;
    int          off;
    old_pc = m_pc;
    off    = int'({m_ins[8:6], m_ins[2:0]});
    if (off >= 32) off = off - 64;
    case (ps)
      2'd1:    m_pc = old_pc + 16'd1;
      2'd2:    m_pc = 16'(int'(old_pc) + off);
      2'd3:    m_pc = a;
      default: m_pc = old_pc;
    endcase
    if (il) begin
      m_ins = imem;
      if (m_icnt != 32'hFFFF_FFFF) m_icnt = m_icnt + 32'd1;
    end
`ifdef IFU_TRACE_EN
    if (rd && m_tq.size() > 0) void'(m_tq.pop_front());
    if (ps[1]) begin
      if (m_tq.size() == 4) begin
        void'(m_tq.pop_front());
        m_ovf = 1'b1;
      end
      m_tq.push_back(old_pc);
    end
`else
    if (rd && ps[1]) m_ovf = 1'b0;
`endif
  endtask

  task automatic check_all(input string tag);
    logic [15:0] exp_data;
    exp_data = (m_tq.size() > 0) ? m_tq[0] : 16'h0000;
    chk({tag, "_pc"},    32'(bus.pc_out),          32'(m_pc));
    chk({tag, "_ins"},   32'(bus.ins_out),         32'(m_ins));
    chk({tag, "_icnt"},  bus.icount_out,           m_icnt);
    chk({tag, "_tval"},  32'(bus.trace_valid_out), 32'(m_tq.size() > 0));
    chk({tag, "_tdata"}, 32'(bus.trace_data_out),  32'(exp_data));
    chk({tag, "_tovf"},  32'(bus.trace_ovf_out),   32'(m_ovf));
  endtask

  task automatic step(input string tag, input logic [1:0] ps, input logic il,
                      input logic [15:0] imem, input logic [15:0] a, input logic rd);
    bus.ps_in        = ps;
    bus.il_in        = il;
    bus.imem_data_in = imem;
    bus.a_in         = a;
    bus.trace_rd_in  = rd;
    @(posedge clk);
    model_clock(ps, il, imem, a, rd);
    #1;
    check_all(tag);
  endtask

  // Called just after a clock edge: reset lands mid-cycle and releases before the next edge
  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.ps_in = 2'b00; bus.il_in = 1'b0; bus.imem_data_in = '0; bus.a_in = '0; bus.trace_rd_in = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst0");
    @(posedge clk);
    #1 check_all("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Increment sequence from the reset PC
    chk("inc_start", 32'(bus.pc_out), 32'h0010);
    step("inc1", 2'b01, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("inc1_const", 32'(bus.pc_out), 32'h0011);
    step("inc2", 2'b01, 1'b0, 16'h0, 16'h0, 1'b0);
    step("inc3", 2'b01, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("inc3_const", 32'(bus.pc_out), 32'h0013);
    chk("inc3_ins", 32'(bus.ins_out), 32'h0);
    chk("inc3_icnt", bus.icount_out, 32'h0);

    // Increment wrap at the top of the address space
    step("jmp_ffff", 2'b11, 1'b0, 16'h0, 16'hFFFF, 1'b0);
    step("wrap", 2'b01, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("wrap_const", 32'(bus.pc_out), 32'h0000);

    // Backward branch by one, then forward branch wrapping through zero
    step("set5", 2'b11, 1'b1, 16'h01C7, 16'h0005, 1'b0);
    step("br_m1", 2'b10, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("br_m1_const", 32'(bus.pc_out), 32'h0004);
    step("setfff0", 2'b11, 1'b1, 16'h00C7, 16'hFFF0, 1'b0);
    step("br_p31", 2'b10, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("br_p31_const", 32'(bus.pc_out), 32'h000F);

    // Branch uses the pre-load instruction while a new one loads
    step("br_load", 2'b10, 1'b1, 16'h0000, 16'h0, 1'b0);

    // Load and jump in the same cycle
    step("ld_jmp", 2'b11, 1'b1, 16'hABCD, 16'h1234, 1'b0);
    chk("ld_jmp_ins", 32'(bus.ins_out), 32'hABCD);
    chk("ld_jmp_pc", 32'(bus.pc_out), 32'h1234);
    chk("ld_jmp_icnt", bus.icount_out, 32'd4);

    // Trace overflow: jumps from PCs 0x10,1,2,3,4,5
    mid_reset("tr_rst");
    for (int i = 1; i <= 6; i++) step("tr_jmp", 2'b11, 1'b0, 16'h0, 16'(i), 1'b0);
`ifdef IFU_TRACE_EN
    chk("tr_ovf", 32'(bus.trace_ovf_out), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      chk("tr_pop_data", 32'(bus.trace_data_out), 32'(i));
      step("tr_pop", 2'b00, 1'b0, 16'h0, 16'h0, 1'b1);
    end
    chk("tr_empty", 32'(bus.trace_valid_out), 32'd0);
    chk("tr_ovf_sticky", 32'(bus.trace_ovf_out), 32'd1);
`else
    chk("tr_off_ovf", 32'(bus.trace_ovf_out), 32'd0);
    chk("tr_off_valid", 32'(bus.trace_valid_out), 32'd0);
`endif
    step("tr_rd_empty", 2'b00, 1'b0, 16'h0, 16'h0, 1'b1);

    // Mid-cycle reset after seven loads
    mid_reset("pre7");
    for (int i = 0; i < 7; i++) step("ld7", 2'b01, 1'b1, 16'(i * 3 + 1), 16'h0, 1'b0);
    chk("ld7_icnt", bus.icount_out, 32'd7);
    mid_reset("rst7");
    chk("rst7_pc", 32'(bus.pc_out), 32'h0010);
    chk("rst7_icnt", bus.icount_out, 32'd0);

    // Random traffic with occasional mid-cycle resets
    for (int n = 0; n < 600; n++) begin
      logic [1:0] ps;
      ps = 2'($urandom_range(0, 3));
      step("rnd", ps, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 79) == 0) mid_reset("rnd_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
